// File: rtl/serial_comp_sequencer_pkg.sv
// Shared encodings for the bit-serial magnitude comparator: FSM states and
// the 2-bit per-bit result code, plus the mapping from result code to flags.
package serial_comp_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RES_EQ = 2'b00,
        RES_LT = 2'b01,
        RES_GT = 2'b10
    } res_t;

    // Flags are packed {gt, eq, lt}
    function automatic logic [2:0] flags_of(res_t r);
        case (r)
            RES_GT:  flags_of = 3'b100;
            RES_LT:  flags_of = 3'b001;
            default: flags_of = 3'b010;
        endcase
    endfunction

endpackage

// File: rtl/comp_bit_cell.sv
// Combinational 1-bit compare cell; the bit pair selects one of four
// precomputed {gt, eq, lt} patterns.
module comp_bit_cell (
    input  logic a_i,
    input  logic b_i,
    output logic gt,
    output logic eq,
    output logic lt
);

    logic [2:0] sel;

    always_comb begin
        sel = 3'b010;
        case ({a_i, b_i})
            2'b00:   sel = 3'b010;
            2'b01:   sel = 3'b001;
            2'b10:   sel = 3'b100;
            2'b11:   sel = 3'b010;
            default: sel = 3'b010;
        endcase
    end

    assign {gt, eq, lt} = sel;

endmodule

// File: rtl/serial_comp_sequencer.sv
// MSB-first serial magnitude compare: walks one bit per clock through a
// single compare cell and stops at the first differing bit.
module serial_comp_sequencer
    import serial_comp_sequencer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             a_gt_b,
    output logic             a_eq_b,
    output logic             a_lt_b
);

    localparam int IDXW = $clog2(WIDTH);
    localparam logic [IDXW-1:0] IDX_MAX = IDXW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [IDXW-1:0]  idx, idx_nxt;
    logic [WIDTH-1:0] opa, opa_nxt, opb, opb_nxt;
    logic [2:0]       flags, flags_nxt;
    logic             cell_gt, cell_eq, cell_lt;
    res_t             res;

    comp_bit_cell u_cell (
        .a_i (opa[idx]),
        .b_i (opb[idx]),
        .gt  (cell_gt),
        .eq  (cell_eq),
        .lt  (cell_lt)
    );

    always_comb begin
        res = RES_EQ;
        if (cell_gt)      res = RES_GT;
        else if (cell_lt) res = RES_LT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            idx   <= IDX_MAX;
            opa   <= '0;
            opb   <= '0;
            flags <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            opa   <= opa_nxt;
            opb   <= opb_nxt;
            flags <= flags_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        opa_nxt   = opa;
        opb_nxt   = opb;
        flags_nxt = flags;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    opa_nxt   = a;
                    opb_nxt   = b;
                    idx_nxt   = IDX_MAX;
                    flags_nxt = '0;
                    state_nxt = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                // Exit at idx==0 on equality, so idx never wraps
                if (!cell_eq || idx == '0) begin
                    flags_nxt = flags_of(res);
                    state_nxt = ST_DONE;
                end else begin
                    idx_nxt = idx - 1'b1;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_COMPARE);
    assign done = (state == ST_DONE);
    assign {a_gt_b, a_eq_b, a_lt_b} = flags;

endmodule

// File: tb/tb_serial_comp_sequencer.sv
// Directed bench for serial_comp_sequencer (WIDTH=8): latency, flags,
// ignored inputs, async abort and back-to-back operation.
module tb_serial_comp_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       busy, done, a_gt_b, a_eq_b, a_lt_b;

    int checks = 0;
    int errors = 0;
    int dones  = 0;

    serial_comp_sequencer #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .a_gt_b (a_gt_b),
        .a_eq_b (a_eq_b),
        .a_lt_b (a_lt_b)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Observed status packed as {busy, done, gt, eq, lt}
    function automatic logic [31:0] st();
        return {27'd0, busy, done, a_gt_b, a_eq_b, a_lt_b};
    endfunction

    // Issue one start pulse, expect decision `lat` edges after accept
    task automatic run_cmp(input string tag, input logic [7:0] va, input logic [7:0] vb,
                           input int lat, input logic [2:0] fl);
        a = va; b = vb; start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_accept"}, st(), 32'b10000);
        for (int k = 1; k < lat; k++) begin
            step();
            chk({tag, "_busy"}, st(), 32'b10000);
        end
        step();
        chk({tag, "_done"}, st(), {27'd0, 2'b01, fl});
        step();
        chk({tag, "_after"}, st(), {27'd0, 2'b00, fl});
    endtask

    initial begin
        // Reset with random inputs
        for (int k = 0; k < 3; k++) begin
            start = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
            step();
            chk("reset", st(), 32'b0);
        end
        start = 1'b0;
        rst_n = 1'b1;

        // First accept right after reset release; MSB differs
        run_cmp("gt80", 8'h80, 8'h7F, 1, 3'b100);
        run_cmp("lt12", 8'h12, 8'h13, 8, 3'b001);
        run_cmp("eqA5", 8'hA5, 8'hA5, 8, 3'b010);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("eq_hold", st(), 32'b00010);
        end

        // Start re-pulsed and operands disturbed mid-compare
        a = 8'h01; b = 8'h02; start = 1'b1;
        step();
        chk("ign_accept", st(), 32'b10000);
        a = 8'hFF; b = 8'h00;
        for (int k = 1; k < 7; k++) begin
            start = k[0];
            step();
            chk("ign_busy", st(), 32'b10000);
        end
        start = 1'b0;
        dones = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (done) dones++;
            if (k == 0) chk("ign_done", st(), 32'b01001);
        end
        chk("ign_one_done", dones, 1);
        chk("ign_idle", st(), 32'b00001);

        // Asynchronous abort after E3
        a = 8'h0F; b = 8'h0E; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        chk("abort_pre", st(), 32'b10000);
        #2 rst_n = 1'b0;
        #1 chk("abort_now", st(), 32'b0);
        step();
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (done) dones++;
        end
        chk("abort_no_done", dones, 0);
        chk("abort_idle", st(), 32'b0);

        // Start held across two operations
        a = 8'h80; b = 8'h7F; start = 1'b1;
        step();
        chk("b2b_acc1", st(), 32'b10000);
        step();
        chk("b2b_done1", st(), 32'b01100);
        a = 8'h12; b = 8'h13;
        step();
        chk("b2b_idle", st(), 32'b00100);
        step();
        chk("b2b_acc2", st(), 32'b10000);
        start = 1'b0;
        for (int k = 1; k < 8; k++) step();
        chk("b2b_busy2", st(), 32'b10000);
        step();
        chk("b2b_done2", st(), 32'b01001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
